// File: rtl/ls_sequencer_if.sv
// Instruction handshake between the fetch side and the load/store sequencer.
// A transfer happens on a rising clk edge when instr_valid and instr_ready are both 1.
interface ls_sequencer_if;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;

  modport master (output instr, output instr_valid, input instr_ready);
  modport slave  (input instr, input instr_valid, output instr_ready);
endinterface

// File: rtl/ls_sequencer.sv
// Sequences one RV64 LD/SD at a time through decode, address settle, write
// and finish phases, driving register selectors, offset and write enables.
module ls_sequencer #(
  parameter int OFF_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  ls_sequencer_if.slave    bus,
  output logic [4:0]       ra,
  output logic [4:0]       rb,
  output logic [4:0]       rw,
  output logic [OFF_W-1:0] c,
  output logic             we_rf,
  output logic             we_mem,
  output logic             done,
  output logic             illegal,
  output logic [15:0]      retired,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECODE = 3'd1,
    SETTLE = 3'd2,
    WRITE  = 3'd3,
    FINISH = 3'd4
  } state_t;

  state_t      state, state_next;
  logic [31:0] instr_q;
  logic        is_ld;
  logic        dec_ld, dec_sd, legal;
  logic [11:0] imm;

  assign state_dbg       = state;
  assign bus.instr_ready = (state == IDLE) && !rst;

  always_comb begin
    dec_ld = (instr_q[6:0] == 7'b0000011) && (instr_q[14:12] == 3'b011);
    dec_sd = (instr_q[6:0] == 7'b0100011) && (instr_q[14:12] == 3'b011);
    imm    = dec_sd ? {instr_q[31:25], instr_q[11:7]} : instr_q[31:20];
    // Only small non-negative offsets fit the data memory; anything else is rejected.
    legal  = (dec_ld || dec_sd) && ((imm >> OFF_W) == 12'd0);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.instr_valid) state_next = DECODE;
      DECODE:  state_next = legal ? SETTLE : IDLE;
      SETTLE:  state_next = WRITE;
      WRITE:   state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      instr_q <= 32'd0;
      is_ld   <= 1'b0;
      ra      <= 5'd0;
      rb      <= 5'd0;
      rw      <= 5'd0;
      c       <= '0;
      we_rf   <= 1'b0;
      we_mem  <= 1'b0;
      done    <= 1'b0;
      illegal <= 1'b0;
      retired <= 16'd0;
    end else begin
      state   <= state_next;
      we_rf   <= 1'b0;
      we_mem  <= 1'b0;
      done    <= 1'b0;
      illegal <= 1'b0;
      case (state)
        IDLE: if (bus.instr_valid) instr_q <= bus.instr;
        DECODE: begin
          if (legal) begin
            ra    <= dec_sd ? instr_q[24:20] : 5'd0;
            rb    <= instr_q[19:15];
            rw    <= dec_ld ? instr_q[11:7] : 5'd0;
            c     <= imm[OFF_W-1:0];
            is_ld <= dec_ld;
          end else begin
            illegal <= 1'b1;
          end
        end
        // Enables are registered here so they are high exactly during WRITE.
        SETTLE: begin
          we_rf  <= is_ld && (rw != 5'd0);
          we_mem <= !is_ld;
        end
        WRITE:   done    <= 1'b1;
        FINISH:  retired <= retired + 16'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ls_sequencer.sv
// Directed bench for ls_sequencer: LD/SD sequencing, illegal rejection,
// reset during WRITE, back-to-back handshakes and retired-counter wrap.
module tb_ls_sequencer;

  localparam logic [31:0] LD_X5  = 32'h00813283;
  localparam logic [31:0] SD_X7  = 32'h0071B223;
  localparam logic [31:0] BAD_IM = 32'h02013283;
  localparam logic [31:0] BAD_OP = 32'h00000033;
  localparam logic [31:0] LD_X0  = 32'h0000B003;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ra, rb, rw;
  logic [4:0]  c;
  logic        we_rf, we_mem, done, illegal;
  logic [15:0] retired;
  logic [2:0]  state_dbg;

  ls_sequencer_if bus ();

  ls_sequencer #(.OFF_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .ra        (ra),
    .rb        (rb),
    .rw        (rw),
    .c         (c),
    .we_rf     (we_rf),
    .we_mem    (we_mem),
    .done      (done),
    .illegal   (illegal),
    .retired   (retired),
    .state_dbg (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  int          n_total = 0;
  int          n_bad   = 0;
  int          n_rf, n_mem, n_done, n_ill;
  int          n_both  = 0;
  int          n_stray = 0;
  int          hs_cyc[$];
  logic [31:0] exp_q[$];
  logic [15:0] exp_ret;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (we_rf)   n_rf++;
    if (we_mem)  n_mem++;
    if (done)    n_done++;
    if (illegal) n_ill++;
    if (we_rf && we_mem) n_both++;
    if ((we_rf || we_mem) && state_dbg != 3'd3) n_stray++;
    if (bus.instr_valid && bus.instr_ready) hs_cyc.push_back(cyc);
  end

  // driver tasks
  task automatic clr_mon();
    n_rf = 0; n_mem = 0; n_done = 0; n_ill = 0;
    hs_cyc.delete();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w);
    int t;
    t = 0;
    @(negedge clk);
    while (!bus.instr_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("ready_wait", {31'd0, bus.instr_ready}, 32'd1);
    bus.instr       = w;
    bus.instr_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
    bus.instr       = 32'hDEADBEEF;
  endtask

  task automatic run_legal(input string name, input logic [31:0] w,
                           input logic [4:0] era, input logic [4:0] erb,
                           input logic [4:0] erw, input logic [4:0] ec,
                           input logic erf, input logic emem);
    logic [31:0] exp_ops;
    clr_mon();
    exp_q.push_back({12'd0, era, erb, erw, ec});
    send(w);
    chk({name, "_decode"}, {29'd0, state_dbg}, 32'd1);
    step();
    chk({name, "_settle"}, {29'd0, state_dbg}, 32'd2);
    exp_ops = exp_q.pop_front();
    chk({name, "_ops"}, {12'd0, ra, rb, rw, c}, exp_ops);
    chk({name, "_settle_we"}, {30'd0, we_rf, we_mem}, 32'd0);
    step();
    chk({name, "_write_we"}, {30'd0, we_rf, we_mem}, {30'd0, erf, emem});
    step();
    chk({name, "_done"}, {31'd0, done}, 32'd1);
    chk({name, "_finish_we"}, {30'd0, we_rf, we_mem}, 32'd0);
    chk({name, "_ops_held"}, {12'd0, ra, rb, rw, c}, exp_ops);
    step();
    exp_ret = exp_ret + 16'd1;
    chk({name, "_retired"}, {16'd0, retired}, {16'd0, exp_ret});
    chk({name, "_ready"}, {31'd0, bus.instr_ready}, 32'd1);
    chk({name, "_done_n"}, n_done, 32'd1);
    chk({name, "_rf_n"}, n_rf, {31'd0, erf});
    chk({name, "_mem_n"}, n_mem, {31'd0, emem});
  endtask

  task automatic run_illegal(input string name, input logic [31:0] w);
    clr_mon();
    send(w);
    step();
    chk({name, "_illegal"}, {31'd0, illegal}, 32'd1);
    chk({name, "_state"}, {29'd0, state_dbg}, 32'd0);
    chk({name, "_ready"}, {31'd0, bus.instr_ready}, 32'd1);
    step();
    chk({name, "_ill_clear"}, {31'd0, illegal}, 32'd0);
    chk({name, "_ill_n"}, n_ill, 32'd1);
    chk({name, "_we_n"}, n_rf + n_mem, 32'd0);
    chk({name, "_done_n"}, n_done, 32'd0);
    chk({name, "_retired"}, {16'd0, retired}, {16'd0, exp_ret});
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst             = 1'b1;
    bus.instr       = 32'd0;
    bus.instr_valid = 1'b0;
    exp_ret         = 16'd0;
    clr_mon();
    repeat (3) step();
    chk("rst_ready", {31'd0, bus.instr_ready}, 32'd0);
    chk("rst_state", {29'd0, state_dbg}, 32'd0);
    chk("rst_ops", {12'd0, ra, rb, rw, c}, 32'd0);
    chk("rst_flags", {28'd0, we_rf, we_mem, done, illegal}, 32'd0);
    chk("rst_retired", {16'd0, retired}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_release_ready", {31'd0, bus.instr_ready}, 32'd1);

    run_legal("ld_x5", LD_X5, 5'd0, 5'd2, 5'd5, 5'd8, 1'b1, 1'b0);
    run_legal("sd_x7", SD_X7, 5'd7, 5'd3, 5'd0, 5'd4, 1'b0, 1'b1);
    run_illegal("bad_imm", BAD_IM);
    run_illegal("bad_op", BAD_OP);
    run_legal("ld_x0", LD_X0, 5'd0, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0);

    // Reset arriving while the SD store pulse is up.
    clr_mon();
    send(SD_X7);
    step();
    step();
    chk("rstw_in_write", {31'd0, we_mem}, 32'd1);
    rst = 1'b1;
    step();
    chk("rstw_we_mem", {31'd0, we_mem}, 32'd0);
    chk("rstw_state", {29'd0, state_dbg}, 32'd0);
    chk("rstw_ready", {31'd0, bus.instr_ready}, 32'd0);
    chk("rstw_ops", {12'd0, ra, rb, rw, c}, 32'd0);
    chk("rstw_flags", {28'd0, we_rf, we_mem, done, illegal}, 32'd0);
    chk("rstw_retired", {16'd0, retired}, 32'd0);
    exp_ret = 16'd0;
    rst = 1'b0;
    #1;
    chk("rstw_ready_after", {31'd0, bus.instr_ready}, 32'd1);
    step();
    chk("rstw_done_n", n_done, 32'd0);
    chk("rstw_mem_n", n_mem, 32'd1);

    // Preload the counter near its top, then run two LDs with valid held high.
    force dut.retired = 16'hFFFE;
    step();
    release dut.retired;
    exp_ret = 16'hFFFE;
    step();
    chk("preload", {16'd0, retired}, {16'd0, exp_ret});

    clr_mon();
    @(negedge clk);
    bus.instr       = LD_X5;
    bus.instr_valid = 1'b1;
    step();
    chk("b2b_first_decode", {29'd0, state_dbg}, 32'd1);
    repeat (4) step();
    exp_ret = exp_ret + 16'd1;
    chk("b2b_retired_ffff", {16'd0, retired}, {16'd0, exp_ret});
    chk("b2b_idle_ready", {31'd0, bus.instr_ready}, 32'd1);
    step();
    chk("b2b_second_decode", {29'd0, state_dbg}, 32'd1);
    bus.instr_valid = 1'b0;
    repeat (4) step();
    exp_ret = exp_ret + 16'd1;
    chk("b2b_retired_wrap", {16'd0, retired}, {16'd0, exp_ret});
    chk("b2b_hs_n", hs_cyc.size(), 32'd2);
    if (hs_cyc.size() >= 2)
      chk("b2b_hs_gap", hs_cyc[1] - hs_cyc[0], 32'd5);
    chk("b2b_done_n", n_done, 32'd2);
    chk("b2b_rf_n", n_rf, 32'd2);

    chk("we_overlap", n_both, 32'd0);
    chk("we_outside_write", n_stray, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/ls_sequencer.md
LS_SEQUENCER -- requirements
Module: ls_sequencer

Interface
REQ-001 Parameter OFF_W, default 5, SHALL set the offset and address width; 5 matches the 5-bit data-memory address.
REQ-002 CLK  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 RST  input  1  SHALL be the synchronous, active-high reset, sampled on the CLK rising edge.
REQ-004 INSTR  input  32  SHALL carry the RV64 instruction word offered upstream.
REQ-005 INSTR_VALID  input  1  SHALL indicate that INSTR is valid.
REQ-006 INSTR_READY  output  1  SHALL indicate the block can accept an instruction this cycle.
REQ-007 Ra, Rb, Rw  output  5 each  SHALL be the register-file selectors driven to the load/store datapath.
REQ-008 C  output  OFF_W  SHALL be the unsigned address offset driven to the datapath adder.
REQ-009 WE_RF, WE_MEM  output  1 each  SHALL be the register-file and data-memory write enables.
REQ-010 DONE  output  1  SHALL be a one-cycle pulse marking completion of a legal instruction.
REQ-011 ILLEGAL  output  1  SHALL be a one-cycle pulse marking rejection of an instruction.
REQ-012 RETIRED  output  16  SHALL count completed legal instructions.

Function
REQ-013 The FSM SHALL have exactly five states: IDLE, DECODE, SETTLE, WRITE and FINISH.
REQ-014 INSTR_READY SHALL be 1 only in IDLE with RST=0; a handshake SHALL occur on a rising edge with INSTR_VALID=1 and INSTR_READY=1.
REQ-015 On handshake, INSTR SHALL be latched and the FSM SHALL go IDLE->DECODE; INSTR changes outside a handshake SHALL be ignored.
REQ-016 LD SHALL be recognised as opcode 0000011 with funct3 011, giving Rb=rs1[19:15], Rw=rd[11:7], Ra=0 and imm=INSTR[31:20].
REQ-017 SD SHALL be recognised as opcode 0100011 with funct3 011, giving Rb=rs1[19:15], Ra=rs2[24:20], Rw=0 and imm={INSTR[31:25],INSTR[11:7]}.
REQ-018 Any other opcode or funct3, or any imm with a nonzero bit above OFF_W-1, SHALL be illegal; negative offsets are therefore illegal.
REQ-019 DECODE with an illegal instruction SHALL go to IDLE, pulse ILLEGAL high for that next cycle, and leave WE_RF, WE_MEM, DONE and RETIRED unchanged.
REQ-020 DECODE with a legal instruction SHALL go to SETTLE; Ra, Rb, Rw and C (C = imm[OFF_W-1:0]) SHALL be registered at that edge and held stable through FINISH.
REQ-021 SETTLE SHALL last one cycle with both WE signals 0, so the combinational Rb+C address settles.
REQ-022 WRITE SHALL last exactly one cycle: for SD, WE_MEM=1; for LD with rd!=0, WE_RF=1; for LD with rd=0, neither WE asserted.
REQ-023 FINISH SHALL last one cycle with DONE=1, and RETIRED SHALL increment by 1 at the edge leaving FINISH; the FSM then returns to IDLE.
REQ-024 RETIRED SHALL wrap from 0xFFFF to 0x0000.
REQ-025 Address wrap (Rb+C beyond 31) is the datapath's concern; the block SHALL pass the operands unchanged.
REQ-026 Handshake-to-DONE latency SHALL be 4 cycles (DECODE, SETTLE, WRITE, FINISH); maximum throughput SHALL be one instruction per 5 cycles.
REQ-027 WE_RF and WE_MEM SHALL never be 1 in the same cycle, and SHALL be 0 in every state except WRITE.
REQ-028 All outputs except INSTR_READY SHALL be registered.

Reset
REQ-029 While RST=1, the block SHALL force state IDLE and drive INSTR_READY=0.
REQ-030 While RST=1, Ra, Rb, Rw and C SHALL be 0, WE_RF, WE_MEM, DONE and ILLEGAL SHALL be 0, and RETIRED SHALL be 0x0000.
REQ-031 RST asserted in any state, including WRITE, SHALL take effect at that edge: the write pulse is cut and no DONE or RETIRED increment occurs.
REQ-032 INSTR_READY SHALL be 1 in the first cycle after RST deasserts.

Verification
REQ-033 The bench SHALL cover LD x5,8(x2), INSTR=0x00813283, handshake at edge k -> Rb=2, C=8, Rw=5, Ra=0 from k+2; WE_RF=1 in WRITE only; DONE at k+4; RETIRED=1.
REQ-034 The bench SHALL cover SD x7,4(x3), INSTR=0x0071B223 -> Ra=7, Rb=3, C=4; WE_MEM=1 for exactly one cycle; WE_RF=0 throughout; DONE once.
REQ-035 The bench SHALL cover illegal INSTR 0x02013283 (imm=32) and 0x00000033 -> ILLEGAL pulse two cycles after the handshake, no WE pulse, RETIRED unchanged, INSTR_READY back to 1.
REQ-036 The bench SHALL cover LD x0,0(x1), INSTR=0x0000B003 -> no WE_RF pulse; DONE=1; RETIRED increments.
REQ-037 The bench SHALL cover RST=1 asserted during WRITE of an SD -> WE_MEM=0 the next cycle, all outputs reset, INSTR_READY=1 one cycle after RST drops.
REQ-038 The bench SHALL cover back-to-back LDs with INSTR_VALID held at 1 -> handshakes 5 cycles apart, and RETIRED preloaded via 0xFFFF completions wrapping to 0x0000.
